// File: rtl/mem_stage.sv
// Memory stage of the pipeline: 256x8 data memory with registered reads,
// branch/jump redirect generation and the MEM/WB pipeline register.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  MEM_aluout,
  input  logic [7:0]  MEM_read_data2,
  input  logic [31:0] MEM_reg_write_addr,
  input  logic [31:0] MEM_branch_addr,
  input  logic [31:0] MEM_jump_addr,
  input  logic        MEM_zr,
  input  logic        MEM_ng,
  input  logic        MEM_cr,
  input  logic        MEM_ov,
  input  logic        MEM_Branch,
  input  logic        MEM_BranchFlip,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic        MEM_Jump,
  input  logic        MEM_RegWrite,
  input  logic        MEM_MemtoReg,
  output logic        pc_redirect,
  output logic [31:0] redirect_addr,
  output logic        flush,
  output logic        stall,
  output logic [7:0]  WB_aluout,
  output logic [7:0]  WB_mem_data,
  output logic [31:0] WB_reg_write_addr,
  output logic        WB_RegWrite,
  output logic        WB_MemtoReg
);

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] mem [256];
  logic [7:0] rd_data;
  logic       is_load;
  logic       branch_taken;
  logic       in_idle;

  // Flags are carried for a later revision; fold them so nothing dangles.
  logic unused_flags;
  assign unused_flags = ^{MEM_ng, MEM_cr, MEM_ov};

  // A simultaneous read+write is a store, never a load.
  assign is_load      = MEM_MemRead & ~MEM_MemWrite;
  assign branch_taken = MEM_Branch & (MEM_zr ^ MEM_BranchFlip);
  assign in_idle      = (state == IDLE) & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:      next_state = is_load ? LOAD_WAIT : IDLE;
      LOAD_WAIT: next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    stall         = in_idle & is_load;
    pc_redirect   = in_idle & (MEM_Jump | branch_taken);
    flush         = pc_redirect;
    redirect_addr = 32'h0;
    if (pc_redirect) redirect_addr = MEM_Jump ? MEM_jump_addr : MEM_branch_addr;
  end

  // Memory array is never reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (in_idle) begin
      if (MEM_MemWrite) mem[MEM_aluout] <= MEM_read_data2;
      if (is_load)      rd_data <= mem[MEM_aluout];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      WB_aluout         <= 8'h0;
      WB_mem_data       <= 8'h0;
      WB_reg_write_addr <= 32'h0;
      WB_RegWrite       <= 1'b0;
      WB_MemtoReg       <= 1'b0;
    end else if (state == LOAD_WAIT) begin
      WB_aluout         <= MEM_aluout;
      WB_mem_data       <= rd_data;
      WB_reg_write_addr <= MEM_reg_write_addr;
      WB_RegWrite       <= MEM_RegWrite;
      WB_MemtoReg       <= MEM_MemtoReg;
    end else begin
      // The first cycle of a load leaves a bubble in WB.
      WB_aluout         <= MEM_aluout;
      WB_reg_write_addr <= MEM_reg_write_addr;
      WB_RegWrite       <= is_load ? 1'b0 : MEM_RegWrite;
      WB_MemtoReg       <= is_load ? 1'b0 : MEM_MemtoReg;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of single-cycle vectors plus hand-written
// load, redirect-on-load and reset sequences checked against a memory model.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic [7:0]  MEM_aluout;
  logic [7:0]  MEM_read_data2;
  logic [31:0] MEM_reg_write_addr;
  logic [31:0] MEM_branch_addr;
  logic [31:0] MEM_jump_addr;
  logic        MEM_zr, MEM_ng, MEM_cr, MEM_ov;
  logic        MEM_Branch, MEM_BranchFlip, MEM_MemRead, MEM_MemWrite;
  logic        MEM_Jump, MEM_RegWrite, MEM_MemtoReg;
  logic        pc_redirect;
  logic [31:0] redirect_addr;
  logic        flush;
  logic        stall;
  logic [7:0]  WB_aluout;
  logic [7:0]  WB_mem_data;
  logic [31:0] WB_reg_write_addr;
  logic        WB_RegWrite;
  logic        WB_MemtoReg;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .MEM_aluout(MEM_aluout), .MEM_read_data2(MEM_read_data2),
    .MEM_reg_write_addr(MEM_reg_write_addr), .MEM_branch_addr(MEM_branch_addr),
    .MEM_jump_addr(MEM_jump_addr),
    .MEM_zr(MEM_zr), .MEM_ng(MEM_ng), .MEM_cr(MEM_cr), .MEM_ov(MEM_ov),
    .MEM_Branch(MEM_Branch), .MEM_BranchFlip(MEM_BranchFlip),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_Jump(MEM_Jump), .MEM_RegWrite(MEM_RegWrite), .MEM_MemtoReg(MEM_MemtoReg),
    .pc_redirect(pc_redirect), .redirect_addr(redirect_addr), .flush(flush),
    .stall(stall), .WB_aluout(WB_aluout), .WB_mem_data(WB_mem_data),
    .WB_reg_write_addr(WB_reg_write_addr), .WB_RegWrite(WB_RegWrite),
    .WB_MemtoReg(WB_MemtoReg)
  );

  // ctl bits: [7]zr [6]Branch [5]BranchFlip [4]MemRead [3]MemWrite [2]Jump [1]RegWrite [0]MemtoReg
  typedef struct {
    string       name;
    logic [7:0]  alu;
    logic [7:0]  d2;
    logic [31:0] rd;
    logic [31:0] br;
    logic [31:0] ja;
    logic [7:0]  ctl;
    logic        e_stall;
    logic        e_redir;
    logic [31:0] e_raddr;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_mem [256];
  logic [7:0] exp_q [$];
  logic [7:0] last_load;
  vec_t       vecs [9];
  vec_t       nop_v;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #90000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    MEM_aluout         = v.alu;
    MEM_read_data2     = v.d2;
    MEM_reg_write_addr = v.rd;
    MEM_branch_addr    = v.br;
    MEM_jump_addr      = v.ja;
    MEM_zr             = v.ctl[7];
    MEM_Branch         = v.ctl[6];
    MEM_BranchFlip     = v.ctl[5];
    MEM_MemRead        = v.ctl[4];
    MEM_MemWrite       = v.ctl[3];
    MEM_Jump           = v.ctl[2];
    MEM_RegWrite       = v.ctl[1];
    MEM_MemtoReg       = v.ctl[0];
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_redirect"}, pc_redirect, 0);
    check({tag, "_flush"}, flush, 0);
    check({tag, "_raddr"}, redirect_addr, 0);
    check({tag, "_wb_alu"}, WB_aluout, 0);
    check({tag, "_wb_mem"}, WB_mem_data, 0);
    check({tag, "_wb_rd"}, WB_reg_write_addr, 0);
    check({tag, "_wb_rw"}, WB_RegWrite, 0);
    check({tag, "_wb_mtr"}, WB_MemtoReg, 0);
  endtask

  // Single non-load cycle: combinational outputs before the edge, WB after.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check({v.name, "_stall"}, stall, v.e_stall);
    check({v.name, "_redirect"}, pc_redirect, v.e_redir);
    check({v.name, "_flush"}, flush, v.e_redir);
    check({v.name, "_raddr"}, redirect_addr, v.e_raddr);
    @(posedge clk);
    #1;
    if (v.ctl[3]) model_mem[v.alu] = v.d2;
    check({v.name, "_wb_alu"}, WB_aluout, v.alu);
    check({v.name, "_wb_rd"}, WB_reg_write_addr, v.rd);
    check({v.name, "_wb_rw"}, WB_RegWrite, v.ctl[1]);
    check({v.name, "_wb_mtr"}, WB_MemtoReg, v.ctl[0]);
  endtask

  // Two-cycle load with inputs held; optional taken branch on the load.
  task automatic do_load(input string name, input logic [7:0] addr,
                         input logic [31:0] rd, input logic with_branch);
    vec_t v;
    logic [7:0] got_exp;
    v = nop_v;
    v.alu = addr;
    v.rd  = rd;
    v.br  = 32'h40;
    v.ctl = with_branch ? 8'b1101_0011 : 8'b0001_0011;
    @(negedge clk);
    drive(v);
    exp_q.push_back(model_mem[addr]);
    #1;
    check({name, "_stall_idle"}, stall, 1);
    check({name, "_redir_idle"}, pc_redirect, with_branch);
    check({name, "_raddr_idle"}, redirect_addr, with_branch ? 32'h40 : 32'h0);
    @(posedge clk);
    #1;
    check({name, "_stall_wait"}, stall, 0);
    check({name, "_redir_wait"}, pc_redirect, 0);
    check({name, "_bubble_rw"}, WB_RegWrite, 0);
    check({name, "_bubble_mtr"}, WB_MemtoReg, 0);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_queue: got empty expected entry", name);
    end else begin
      got_exp = exp_q.pop_front();
      last_load = got_exp;
      check({name, "_wb_mem"}, WB_mem_data, got_exp);
    end
    check({name, "_wb_rw"}, WB_RegWrite, 1);
    check({name, "_wb_mtr"}, WB_MemtoReg, 1);
    check({name, "_wb_rd"}, WB_reg_write_addr, rd);
    @(negedge clk);
    drive(nop_v);
  endtask

  initial begin
    vec_t v;
    nop_v = '{"nop", 8'h00, 8'h00, 32'h0, 32'h0, 32'h0, 8'b0000_0000, 1'b0, 1'b0, 32'h0};
    vecs[0] = '{"alu_pass", 8'h7F, 8'h00, 32'd5, 32'h0, 32'h0, 8'b0000_0010, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{"br_taken", 8'h01, 8'h00, 32'd1, 32'h40, 32'h0, 8'b1100_0000, 1'b0, 1'b1, 32'h40};
    vecs[2] = '{"br_flip", 8'h02, 8'h00, 32'd2, 32'h40, 32'h0, 8'b1110_0000, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{"br_flip_nz", 8'h03, 8'h00, 32'd4, 32'h44, 32'h0, 8'b0110_0010, 1'b0, 1'b1, 32'h44};
    vecs[4] = '{"jump_prio", 8'h04, 8'h00, 32'd6, 32'h40, 32'h80, 8'b1100_0100, 1'b0, 1'b1, 32'h80};
    vecs[5] = '{"jump_only", 8'h05, 8'h00, 32'd9, 32'h40, 32'h12345678, 8'b0000_0110, 1'b0, 1'b1, 32'h12345678};
    vecs[6] = '{"store_10", 8'h10, 8'h5A, 32'd0, 32'h0, 32'h0, 8'b0000_1000, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{"store_00", 8'h00, 8'hC3, 32'd0, 32'h0, 32'h0, 8'b0000_1000, 1'b0, 1'b0, 32'h0};
    vecs[8] = '{"rw_both_ff", 8'hFF, 8'h33, 32'd10, 32'h0, 32'h0, 8'b0001_1000, 1'b0, 1'b0, 32'h0};

    MEM_ng = 1'b0;
    MEM_cr = 1'b0;
    MEM_ov = 1'b0;
    reset = 1'b1;
    drive(nop_v);
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    do_load("load_10", 8'h10, 32'd3, 1'b0);
    run_vec(vecs[0]);
    check("wb_mem_hold", WB_mem_data, last_load);
    do_load("load_ff_br", 8'hFF, 32'd7, 1'b1);
    do_load("load_00", 8'h00, 32'd8, 1'b0);

    // Write coinciding with reset must not land.
    v = '{"store_20", 8'h20, 8'h11, 32'd0, 32'h0, 32'h0, 8'b0000_1000, 1'b0, 1'b0, 32'h0};
    run_vec(v);
    @(negedge clk);
    v.d2 = 8'h99;
    drive(v);
    reset = 1'b1;
    #1;
    check_all_zero("rst_write");
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    drive(nop_v);
    do_load("load_20", 8'h20, 32'd2, 1'b0);

    // Reset asserted asynchronously during LOAD_WAIT aborts the load.
    v = nop_v;
    v.alu = 8'h10;
    v.rd  = 32'd3;
    v.br  = 32'h40;
    v.ctl = 8'b1101_0011;
    @(negedge clk);
    drive(v);
    #1;
    check("midload_stall", stall, 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midload_rst");
    @(posedge clk);
    #1;
    check("midload_rw_held", WB_RegWrite, 0);
    check("midload_mem_held", WB_mem_data, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(nop_v);
    #1;
    check("after_rst_stall", stall, 0);
    do_load("load_10_after_rst", 8'h10, 32'd3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
